issue_scoreboard_ctrl: RTL and testbench
========================================

// Module: issue_scoreboard_ctrl
// PURPOSE
//  Dual-issue hazard controller between the decode stage and the execute lanes.
//  Tracks an in-flight write counter per architectural register and decides each cycle whether lane 0, lane 1, both or neither of the decoded pair issues.
//  Drives the decode stall, and applies branch-taken flush suppression.
// PARAMETERS
//  NUM_REGS  8  architectural registers (register index width = $clog2(NUM_REGS), 3 at default)
//  LAT_W     3  scoreboard counter width; every latency must be <= 2**LAT_W-1
//  ALU_LAT   1  result latency of ALU-class opcodes
//  LOAD_LAT  2  result latency of LOAD
//  MUL_LAT   3  result latency of MUL
// PORTS
//  clk              in   1   single clock, rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  is_branch_taken  in   1   flush: suppress all issue this cycle
//  vld0, vld1       in   1   decoded instruction present in lane 0 / lane 1 (lane 0 is older)
//  opc0, opc1       in   4   opcode
//  imm0, imm1       in   1   immediate flag; when 1 the lane has no rs2 read
//  rd0/rs1_0/rs2_0  in   3   lane 0 register fields (same set rd1/rs1_1/rs2_1 for lane 1)
//  issue0, issue1   out  1   lane issues this cycle (combinational)
//  stall            out  1   (vld0&!issue0)|(vld1&!issue1), forced 0 on flush
//  busy_vec         out  NUM_REGS  registered: bit r = counter[r]!=0
// BEHAVIOUR
//  - Reset: all counters 0, busy_vec=0. issue0, issue1 and stall are forced 0 while reset_n=0. Reset mid-operation discards all pending writes immediately.
//  - Opcode classes: 0 NOP (no read, no write); 1-7 ALU; 8 MUL; 9 LOAD; A STORE (reads rs1/rs2, no write); C BRANCH (reads, no write). B, D-F decode as ALU.
//  - busy(r) = counter[r]!=0.
//  - Lane 0 hazard:
//    - RAW: busy(rs1_0), or (!imm0 & busy(rs2_0)).
//    - WAW: lane writes rd and busy(rd0).
//    - issue0 = vld0 & !flush & !hazard0.
//  - Lane 1 issue (in-order): issue1 = issue0 & vld1 & !hazard1 & !pair_conflict.
//    - pair_conflict applies only when lane 0 writes rd0 and either:
//      - rd0 equals rs1_1, or (!imm1 and rd0 equals rs2_1); or
//      - rd0 equals rd1 and lane 1 writes.
//    - pair_conflict also holds when both opcodes are BRANCH (single branch unit).
//  - Counter update at each clk edge:
//    - Decrement, saturating at 0.
//    - Then, for each issuing lane that writes, load counter[rd] with its class latency.
//    - The load overrides the decrement.
//    - The lanes never target the same rd, because pair_conflict prevents it.
//  - Latency: a writer issued at edge N gives counter=LAT at cycle N+1, decrementing each cycle. A dependent instruction may issue the first cycle busy(r)=0.
//  - Flush (is_branch_taken=1):
//    - issue0=issue1=0 and stall=0.
//    - Counters keep decrementing, because in-flight writes still complete.
//  - Partial issue: issue0=1 & issue1=0 with vld1=1 gives stall=1. Decode realigns lane 1 into lane 0.
//  - Register 0 has no special handling; it is tracked like any other register.
// CONFIGURATION
//  DECODE_FWD_EN
//    - Defined: RAW checks treat counter==1 as not busy, because the result is forwarded next cycle.
//    - WAW checks and busy_vec are unchanged.
//    - Not defined: any nonzero counter blocks RAW.
// STRUCTURE
//  - Package decode_pkg holds:
//    - Opcode constants OP_NOP=4'h0, OP_MUL=4'h8, OP_LOAD=4'h9, OP_STORE=4'hA, OP_BRANCH=4'hC.
//    - Function op_latency(opc) returning the class latency.
//    - Functions op_writes_rd(opc) and op_reads(opc).
//  - Sub-module scoreboard_entry, one instance per register:
//    - Inputs: load, load_val, fwd_ok.
//    - Outputs: busy, raw_busy.
//    - Contains the LAT_W countdown register with async reset.
// TESTING
//  T1 ADD r1,r2,r3 / ADD r4,r1,r5, scoreboard empty -> issue0=1, issue1=0, stall=1; busy_vec[1]=1 next cycle.
//  T2 MUL r2 at cycle 0, then ADD r3,r2,r2 in lane 0 -> issue0=0 in cycles 1-3, issue0=1 in cycle 4.
//     - With DECODE_FWD_EN defined -> issue0=1 in cycle 3.
//  T3 BRANCH / BRANCH pair, no hazards -> issue0=1, issue1=0, stall=1.
//  T4 is_branch_taken=1 with both lanes valid and hazard-free -> issue0=issue1=stall=0.
//     - A LOAD r6 issued the previous cycle still shows busy_vec[6]=1, then clears after 2 cycles.
//  T5 LOAD r4 at cycle 0, then lane 0 ADD r4,r1,r2 (imm=1) -> WAW stall until counter[4]=0.
//     - Same with DECODE_FWD_EN defined, since WAW is unaffected by forwarding.
//  T6 reset_n low while MUL r7 counter=2 -> busy_vec=0 and issue/stall=0 immediately.
//     - After release, ADD r1,r7,r7 issues on the first cycle.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Brief    : Opcode constants and class helpers for the issue scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MUL    = 4'h8;
  localparam logic [3:0] OP_LOAD   = 4'h9;
  localparam logic [3:0] OP_STORE  = 4'hA;
  localparam logic [3:0] OP_BRANCH = 4'hC;

  function automatic logic op_writes_rd(input logic [3:0] opc);
    return !(opc == OP_NOP || opc == OP_STORE || opc == OP_BRANCH);
  endfunction

  function automatic logic op_reads(input logic [3:0] opc);
    return (opc != OP_NOP);
  endfunction

  // Non-writing classes report 0; undecoded values fall into the ALU class.
  function automatic int op_latency(input logic [3:0] opc,
                                    input int alu_lat  = 1,
                                    input int load_lat = 2,
                                    input int mul_lat  = 3);
    if (!op_writes_rd(opc)) return 0;
    if (opc == OP_MUL)      return mul_lat;
    if (opc == OP_LOAD)     return load_lat;
    return alu_lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scoreboard_entry.sv
`default_nettype none
// ============================================================================
//  Module   : scoreboard_entry
//  Brief    : Per-register in-flight write countdown with busy / RAW-busy flags.
//  Revision : 1.0  initial release
// ============================================================================
module scoreboard_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             fwd_ok,
  output logic             busy,
  output logic             raw_busy
);

  logic [LAT_W-1:0] r_cnt;

  // A new writer overrides the running countdown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_cnt <= '0;
    else if (load)            r_cnt <= load_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign busy     = (r_cnt != '0);
  assign raw_busy = fwd_ok ? (r_cnt > LAT_W'(1)) : busy;

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scoreboard_ctrl
//  Brief    : Dual-issue hazard controller; optional macro DECODE_FWD_EN lets
//             RAW checks ignore a counter of 1 (result forwarded).
//  Revision : 1.0  initial release
// ============================================================================
module issue_scoreboard_ctrl
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int LAT_W    = 3,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 3,
  localparam int RW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                is_branch_taken,
  input  logic                vld0,
  input  logic                vld1,
  input  logic [3:0]          opc0,
  input  logic [3:0]          opc1,
  input  logic                imm0,
  input  logic                imm1,
  input  logic [RW-1:0]       rd0,
  input  logic [RW-1:0]       rs1_0,
  input  logic [RW-1:0]       rs2_0,
  input  logic [RW-1:0]       rd1,
  input  logic [RW-1:0]       rs1_1,
  input  logic [RW-1:0]       rs2_1,
  output logic                issue0,
  output logic                issue1,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic                w_fwd_ok;
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_raw_busy;
  logic                w_wr0, w_wr1, w_rd_0, w_rd_1;
  logic                w_haz0, w_haz1, w_pair;
  logic [LAT_W-1:0]    w_lat0, w_lat1;

`ifdef DECODE_FWD_EN
  assign w_fwd_ok = 1'b1;
`else
  assign w_fwd_ok = 1'b0;
`endif

  assign w_wr0  = op_writes_rd(opc0);
  assign w_wr1  = op_writes_rd(opc1);
  assign w_rd_0 = op_reads(opc0);
  assign w_rd_1 = op_reads(opc1);
  assign w_lat0 = LAT_W'(op_latency(opc0, ALU_LAT, LOAD_LAT, MUL_LAT));
  assign w_lat1 = LAT_W'(op_latency(opc1, ALU_LAT, LOAD_LAT, MUL_LAT));

  assign w_haz0 = (w_rd_0 & (w_raw_busy[rs1_0] | (!imm0 & w_raw_busy[rs2_0])))
                | (w_wr0 & w_busy[rd0]);
  assign w_haz1 = (w_rd_1 & (w_raw_busy[rs1_1] | (!imm1 & w_raw_busy[rs2_1])))
                | (w_wr1 & w_busy[rd1]);

  // Intra-pair dependency on lane 0's result, or two branches for one unit.
  assign w_pair = (w_wr0 & ((w_rd_1 & ((rd0 == rs1_1) | (!imm1 & (rd0 == rs2_1))))
                          | (w_wr1 & (rd0 == rd1))))
                | ((opc0 == OP_BRANCH) & (opc1 == OP_BRANCH));

  assign issue0 = reset_n & vld0 & !is_branch_taken & !w_haz0;
  assign issue1 = issue0 & vld1 & !w_haz1 & !w_pair;
  assign stall  = reset_n & !is_branch_taken & ((vld0 & !issue0) | (vld1 & !issue1));

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    logic w_ld0, w_ld1;
    assign w_ld0 = issue0 & w_wr0 & (rd0 == RW'(r));
    assign w_ld1 = issue1 & w_wr1 & (rd1 == RW'(r));

    scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (w_ld0 | w_ld1),
      .load_val (w_ld0 ? w_lat0 : w_lat1),
      .fwd_ok   (w_fwd_ok),
      .busy     (w_busy[r]),
      .raw_busy (w_raw_busy[r])
    );
  end

  assign busy_vec = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_scoreboard_ctrl
//  Brief    : Directed self-checking bench for issue_scoreboard_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       is_branch_taken = 1'b0;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic [3:0] opc0 = '0, opc1 = '0;
  logic       imm0 = 1'b0, imm1 = 1'b0;
  logic [2:0] rd0 = '0, rs1_0 = '0, rs2_0 = '0;
  logic [2:0] rd1 = '0, rs1_1 = '0, rs2_1 = '0;
  logic       issue0, issue1, stall;
  logic [7:0] busy_vec;

  int n_chk  = 0;
  int n_fail = 0;

  issue_scoreboard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .is_branch_taken(is_branch_taken),
    .vld0(vld0), .vld1(vld1), .opc0(opc0), .opc1(opc1),
    .imm0(imm0), .imm1(imm1),
    .rd0(rd0), .rs1_0(rs1_0), .rs2_0(rs2_0),
    .rd1(rd1), .rs1_1(rs1_1), .rs2_1(rs2_1),
    .issue0(issue0), .issue1(issue1), .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic l0(input logic v, input logic [3:0] o, input logic im,
                    input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    vld0 = v; opc0 = o; imm0 = im; rd0 = d; rs1_0 = a; rs2_0 = b;
  endtask

  task automatic l1(input logic v, input logic [3:0] o, input logic im,
                    input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    vld1 = v; opc1 = o; imm1 = im; rd1 = d; rs1_1 = a; rs2_1 = b;
  endtask

  task automatic idle();
    vld0 = 1'b0; vld1 = 1'b0; is_branch_taken = 1'b0;
  endtask

  // Advance to just after the next rising edge; new inputs settle before checks.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset: outputs held low even with a hazard-free valid lane.
    l0(1, 4'h1, 0, 3'd1, 3'd2, 3'd3);
    settle();
    chk("rst_issue0", issue0, 0);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy_vec, 8'h00);
    step(); step();
    reset_n = 1'b1;
    idle();
    step();

    // T1: dependent pair -> partial issue
    l0(1, 4'h1, 0, 3'd1, 3'd2, 3'd3);
    l1(1, 4'h1, 0, 3'd4, 3'd1, 3'd5);
    settle();
    chk("t1_issue0", issue0, 1);
    chk("t1_issue1", issue1, 0);
    chk("t1_stall", stall, 1);
    step(); idle(); settle();
    chk("t1_busy", busy_vec, 8'h02);
    step();
    chk("t1_busy_clr", busy_vec, 8'h00);

    // Independent pair dual-issues
    l0(1, 4'h1, 0, 3'd1, 3'd2, 3'd3);
    l1(1, 4'h2, 0, 3'd4, 3'd5, 3'd6);
    settle();
    chk("dual_issue1", issue1, 1);
    chk("dual_stall", stall, 0);
    step(); idle(); settle();
    chk("dual_busy", busy_vec, 8'h12);
    step();

    // Lane 1 STORE reading lane 0's rd through rs2
    l0(1, 4'h1, 0, 3'd2, 3'd3, 3'd4);
    l1(1, 4'hA, 0, 3'd0, 3'd5, 3'd2);
    settle();
    chk("pair_store_issue1", issue1, 0);
    step(); idle(); step();

    // T2: MUL r2 then ADD r3,r2,r2
    l0(1, 4'h8, 0, 3'd2, 3'd0, 3'd0);
    settle();
    chk("t2_mul_issue", issue0, 1);
    step();
    l0(1, 4'h1, 0, 3'd3, 3'd2, 3'd2);
    settle();
    chk("t2_busy", busy_vec, 8'h04);
    chk("t2_c1", issue0, 0);
    step();
    chk("t2_c2", issue0, 0);
    step();
`ifdef DECODE_FWD_EN
    chk("t2_c3", issue0, 1);
    step(); idle();
`else
    chk("t2_c3", issue0, 0);
    step();
    chk("t2_c4", issue0, 1);
    step(); idle();
`endif
    step(); step(); step();
    chk("t2_drain", busy_vec, 8'h00);

    // T3: two branches share one unit
    l0(1, 4'hC, 0, 3'd0, 3'd1, 3'd2);
    l1(1, 4'hC, 0, 3'd0, 3'd3, 3'd4);
    settle();
    chk("t3_issue0", issue0, 1);
    chk("t3_issue1", issue1, 0);
    chk("t3_stall", stall, 1);
    step(); idle(); step();

    // T4: flush while a LOAD r6 is in flight
    l0(1, 4'h9, 0, 3'd6, 3'd0, 3'd0);
    step();
    is_branch_taken = 1'b1;
    l0(1, 4'h1, 0, 3'd1, 3'd2, 3'd3);
    l1(1, 4'h1, 0, 3'd4, 3'd5, 3'd7);
    settle();
    chk("t4_issue0", issue0, 0);
    chk("t4_issue1", issue1, 0);
    chk("t4_stall", stall, 0);
    chk("t4_busy_a", busy_vec, 8'h40);
    step();
    chk("t4_busy_b", busy_vec, 8'h40);
    step(); idle(); settle();
    chk("t4_busy_clr", busy_vec, 8'h00);

    // T5: WAW on r4 after LOAD r4
    l0(1, 4'h9, 0, 3'd4, 3'd0, 3'd0);
    step();
    l0(1, 4'h1, 1, 3'd4, 3'd1, 3'd2);
    settle();
    chk("t5_c1", issue0, 0);
    chk("t5_stall", stall, 1);
    step();
    chk("t5_c2", issue0, 0);
    step();
    chk("t5_c3", issue0, 1);
    step(); idle(); step();

    // Immediate flag drops the rs2 read
    l0(1, 4'h9, 0, 3'd4, 3'd0, 3'd0);
    step();
    l0(1, 4'h1, 0, 3'd5, 3'd1, 3'd4);
    settle();
    chk("imm0_raw", issue0, 0);
    imm0 = 1'b1;
    settle();
    chk("imm1_noraw", issue0, 1);
    step(); idle(); step(); step();

    // T6: asynchronous reset with MUL r7 counter at 2
    l0(1, 4'h8, 0, 3'd7, 3'd0, 3'd0);
    step(); idle();
    step();
    l0(1, 4'h1, 0, 3'd1, 3'd2, 3'd3);
    settle();
    chk("t6_pre_busy", busy_vec, 8'h80);
    reset_n = 1'b0;
    settle();
    chk("t6_busy", busy_vec, 8'h00);
    chk("t6_issue0", issue0, 0);
    chk("t6_stall", stall, 0);
    #1 reset_n = 1'b1;
    l0(1, 4'h1, 0, 3'd1, 3'd7, 3'd7);
    settle();
    chk("t6_post_issue", issue0, 1);
    step(); idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
